timer_dev: RTL and testbench

- Memory-mapped countdown timer. Device 0 on the system bridge, window 0x00007F00–0x00007F0F.
- Responder end of the bridge's device interface: receives the forwarded address, write data and gated write enable, and returns read data combinationally.
- Raises an interrupt line that the bridge routes to bit 0 of the CPU interrupt vector.
- Two modes: one-shot (mode 0) and auto-reload periodic (mode 1).

---
 rtl/timer_dev_pkg.sv | 30 +++
 rtl/timer_dev_if.sv | 14 +
 rtl/timer_dev.sv | 116 +++++++++++
 tb/tb_timer_dev.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared register offsets, control bit indices, mode codes and FSM encodings
package timer_dev_pkg;

    localparam int BUS_W = 32;

    typedef logic [3:0] ctrl_t;

    localparam logic [1:0] CTRL_OFS   = 2'b00;
    localparam logic [1:0] PRESET_OFS = 2'b01;
    localparam logic [1:0] COUNT_OFS  = 2'b10;

    localparam int EN      = 0;
    localparam int MODE_LO = 1;
    localparam int MODE_HI = 2;
    localparam int IM      = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] CNT  = 2'b10;
    localparam logic [1:0] INT  = 2'b11;

    // Only the periodic code reloads; the two unassigned codes fall back to one-shot.
    function automatic logic is_periodic(input logic [1:0] mode);
        return mode == MODE_PERIODIC;
    endfunction

endpackage

// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - bridge-to-timer device port bundle
interface timer_dev_if;
    import timer_dev_pkg::*;

    logic [BUS_W-1:0] addr;
    logic             we;
    logic [BUS_W-1:0] wdata;
    logic [BUS_W-1:0] rdata;
    logic             irq;

    modport master (output addr, we, wdata, input rdata, irq);
    modport slave  (input addr, we, wdata, output rdata, irq);

endinterface

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with one-shot and periodic modes
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic       clk,
    input  logic       reset,
    timer_dev_if.slave bus
);

    ctrl_t             ctrl;
    ctrl_t             ctrl_nxt;
    logic [CNT_W-1:0]  preset;
    logic [CNT_W-1:0]  preset_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              irq_flag;
    logic              flag_nxt;
    logic              irq_q;
    logic [1:0]        ofs;
    logic              wr_ctrl;
    logic              wr_preset;
    logic              unused_bits;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign ofs         = bus.addr[3:2];
    assign wr_ctrl     = bus.we && (ofs == CTRL_OFS);
    assign wr_preset   = bus.we && (ofs == PRESET_OFS);
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata};

    always_comb begin
        ctrl_nxt   = ctrl;
        preset_nxt = preset;
        count_nxt  = count;
        state_nxt  = state;
        flag_nxt   = irq_flag;

        case (state)
            IDLE: begin
                if (ctrl[EN]) state_nxt = LOAD;
            end
            LOAD: begin
                count_nxt = preset;
                flag_nxt  = 1'b0;
                state_nxt = CNT;
            end
            CNT: begin
                if (!ctrl[EN]) begin
                    state_nxt = IDLE;
                end else if (count > CNT_ONE) begin
                    count_nxt = count - CNT_ONE;
                end else begin
                    // Covers both COUNT==1 and a zero PRESET; never wraps.
                    count_nxt = '0;
                    state_nxt = INT;
                end
            end
            INT: begin
                flag_nxt = 1'b1;
                if (is_periodic(ctrl[MODE_HI:MODE_LO])) begin
                    state_nxt = LOAD;
                end else begin
                    ctrl_nxt[EN] = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // CPU writes land after the FSM so they win over its EN clear and flag set.
        if (wr_ctrl) begin
            ctrl_nxt = bus.wdata[3:0];
            flag_nxt = 1'b0;
        end
        if (wr_preset) begin
            preset_nxt = bus.wdata[CNT_W-1:0];
            flag_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            state    <= IDLE;
            irq_flag <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl     <= ctrl_nxt;
            preset   <= preset_nxt;
            count    <= count_nxt;
            state    <= state_nxt;
            irq_flag <= flag_nxt;
            irq_q    <= ctrl_nxt[IM] & flag_nxt;
        end
    end

    assign bus.irq = irq_q;

    always_comb begin
        bus.rdata = '0;
        case (ofs)
            CTRL_OFS:   bus.rdata[3:0]       = ctrl;
            PRESET_OFS: bus.rdata[CNT_W-1:0] = preset;
            COUNT_OFS:  bus.rdata[CNT_W-1:0] = count;
            default:    bus.rdata            = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - self-checking bench for timer_dev against a closed-form timing model
module tb_timer_dev;
    import timer_dev_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    timer_dev_if bus ();

    timer_dev #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] o, input logic [31:0] d);
        bus.addr  = BASE | {28'h0, o, 2'b00};
        bus.wdata = d;
        bus.we    = 1'b1;
        step();
        bus.we    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] o, output logic [31:0] d);
        bus.addr = BASE | {28'h0, o, 2'b00};
        #1;
        d = bus.rdata;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        bus.we = 1'b0;
        step();
        reset  = 1'b0;
    endtask

    // Timing model: t = edges since the enabling CTRL write, Q = PRESET with 0 behaving as 1.
    function automatic int q_of(input int p);
        return (p < 1) ? 1 : p;
    endfunction

    function automatic bit exp_flag(input int p, input bit periodic, input int t);
        int q;
        q = q_of(p);
        if (t < q + 3) return 1'b0;
        if (!periodic) return 1'b1;
        return ((t - (q + 3)) % (q + 2)) == 0;
    endfunction

    function automatic int exp_count(input int p, input bit periodic, input int t, input int c0);
        int ph;
        if (t < 2) return c0;
        if (!periodic) return ((t - 2) >= p) ? 0 : p - (t - 2);
        ph = (t - 2) % (q_of(p) + 2);
        return (ph <= p) ? p - ph : 0;
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        reset     = 1'b1;
        bus.addr  = BASE | 32'h4;
        bus.wdata = 32'h55;
        bus.we    = 1'b1;
        step();
        bus.we = 1'b0;
        reset  = 1'b0;
        for (int o = 0; o < 4; o++) begin
            bus_read(2'(o), v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_read ofs=%0d got=%h exp=0", o, v);
            end
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=0", bus.irq);
        end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        do_reset();
        bus_write(CTRL_OFS, 32'hFFFF_FFF8);
        bus_read(CTRL_OFS, v);
        checks++;
        if (v !== 32'h8) begin errors++; $display("FAIL ctrl_mask got=%h exp=8", v); end
        bus_write(PRESET_OFS, 32'hDEAD_BEEF);
        bus_read(PRESET_OFS, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL preset_rw got=%h exp=deadbeef", v); end
        bus_write(COUNT_OFS, 32'h1234);
        bus_write(2'b11, 32'hFFFF);
        bus_read(COUNT_OFS, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL count_ro got=%h exp=0", v); end
        bus_read(2'b11, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reserved got=%h exp=0", v); end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        bus_write(PRESET_OFS, 32'd3);
        bus_write(CTRL_OFS, 32'h9);
        for (int t = 0; t <= 8; t++) begin
            bus_read(COUNT_OFS, v);
            if (t >= 2) begin
                checks++;
                if (v !== 32'(exp_count(3, 1'b0, t, 0))) begin
                    errors++;
                    $display("FAIL oneshot_count t=%0d got=%0d exp=%0d", t, v, exp_count(3, 1'b0, t, 0));
                end
            end
            checks++;
            if (bus.irq !== (t >= 6)) begin
                errors++;
                $display("FAIL oneshot_irq t=%0d got=%b exp=%b", t, bus.irq, (t >= 6));
            end
            step();
        end
        bus_read(CTRL_OFS, v);
        checks++;
        if (v !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl got=%h exp=8", v); end
        step(); step(); step();
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL oneshot_hold got=%b exp=1", bus.irq); end
        bus_write(PRESET_OFS, 32'd3);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL oneshot_clear got=%b exp=0", bus.irq); end
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        do_reset();
        bus_write(PRESET_OFS, 32'd2);
        bus_write(CTRL_OFS, 32'hB);
        for (int t = 0; t <= 18; t++) begin
            bus_read(COUNT_OFS, v);
            if (t >= 2) begin
                checks++;
                if (v !== 32'(exp_count(2, 1'b1, t, 0))) begin
                    errors++;
                    $display("FAIL periodic_count t=%0d got=%0d exp=%0d", t, v, exp_count(2, 1'b1, t, 0));
                end
            end
            checks++;
            if (bus.irq !== exp_flag(2, 1'b1, t)) begin
                errors++;
                $display("FAIL periodic_irq t=%0d got=%b exp=%b", t, bus.irq, exp_flag(2, 1'b1, t));
            end
            step();
        end
    endtask

    task automatic test_zero_preset();
        do_reset();
        bus_write(PRESET_OFS, 32'd0);
        bus_write(CTRL_OFS, 32'h9);
        for (int t = 0; t <= 5; t++) begin
            checks++;
            if (bus.irq !== (t >= 4)) begin
                errors++;
                $display("FAIL zero_irq t=%0d got=%b exp=%b", t, bus.irq, (t >= 4));
            end
            step();
        end
    endtask

    task automatic test_disable();
        logic [31:0] v;
        do_reset();
        bus_write(PRESET_OFS, 32'd10);
        bus_write(CTRL_OFS, 32'h9);
        repeat (5) step();
        bus_read(COUNT_OFS, v);
        checks++;
        if (v !== 32'd7) begin errors++; $display("FAIL disable_pre got=%0d exp=7", v); end
        bus_write(CTRL_OFS, 32'h8);
        repeat (4) step();
        bus_read(COUNT_OFS, v);
        checks++;
        if (v !== 32'd6) begin errors++; $display("FAIL disable_frozen got=%0d exp=6", v); end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL disable_irq got=%b exp=0", bus.irq); end
        bus_write(PRESET_OFS, 32'd5);
        bus_write(CTRL_OFS, 32'h9);
        step(); step();
        bus_read(COUNT_OFS, v);
        checks++;
        if (v !== 32'd5) begin errors++; $display("FAIL disable_reload got=%0d exp=5", v); end
    endtask

    task automatic test_masked();
        logic [31:0] v;
        do_reset();
        bus_write(PRESET_OFS, 32'd1);
        bus_write(CTRL_OFS, 32'h1);
        for (int t = 0; t <= 7; t++) begin
            checks++;
            if (bus.irq !== 1'b0) begin errors++; $display("FAIL masked_irq t=%0d got=%b exp=0", t, bus.irq); end
            step();
        end
        bus_read(CTRL_OFS, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL masked_ctrl got=%h exp=0", v); end
        bus_write(CTRL_OFS, 32'h8);
        step(); step();
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL masked_unmask got=%b exp=0", bus.irq); end
    endtask

    task automatic test_int_priority();
        logic [31:0] v;
        do_reset();
        bus_write(PRESET_OFS, 32'd1);
        bus_write(CTRL_OFS, 32'h9);
        repeat (3) step();
        bus_write(CTRL_OFS, 32'h9);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL int_wr_flag got=%b exp=0", bus.irq); end
        bus_read(CTRL_OFS, v);
        checks++;
        if (v !== 32'h9) begin errors++; $display("FAIL int_wr_ctrl got=%h exp=9", v); end
        for (int t = 0; t <= 4; t++) begin
            checks++;
            if (bus.irq !== (t >= 4)) begin
                errors++;
                $display("FAIL int_wr_restart t=%0d got=%b exp=%b", t, bus.irq, (t >= 4));
            end
            step();
        end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        do_reset();
        bus_write(PRESET_OFS, 32'd20);
        bus_write(CTRL_OFS, 32'hB);
        repeat (5) step();
        reset     = 1'b1;
        bus.addr  = BASE | 32'h4;
        bus.wdata = 32'd7;
        bus.we    = 1'b1;
        step();
        bus.we = 1'b0;
        reset  = 1'b0;
        for (int o = 0; o < 3; o++) begin
            bus_read(2'(o), v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL midreset ofs=%0d got=%h exp=0", o, v); end
        end
        repeat (3) step();
        bus_read(COUNT_OFS, v);
        checks++;
        if (v !== 32'h0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle count=%0d irq=%b exp=0/0", v, bus.irq);
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        int          p;
        int          q;
        int          tmax;
        logic [1:0]  mode;
        logic        im;
        bit          per;
        for (int it = 0; it < 8; it++) begin
            p    = int'($urandom_range(0, 12));
            mode = 2'($urandom_range(0, 3));
            im   = 1'($urandom_range(0, 1));
            per  = (mode == 2'b01);
            q    = q_of(p);
            tmax = 3 * (q + 2) + q + 4;
            do_reset();
            bus_write(PRESET_OFS, 32'(p));
            bus_write(CTRL_OFS, {28'h0, im, mode, 1'b1});
            for (int t = 0; t <= tmax; t++) begin
                bus_read(COUNT_OFS, v);
                checks++;
                if (v !== 32'(exp_count(p, per, t, 0))) begin
                    errors++;
                    $display("FAIL rand_count p=%0d mode=%0d t=%0d got=%0d exp=%0d", p, mode, t, v, exp_count(p, per, t, 0));
                end
                checks++;
                if (bus.irq !== (im & exp_flag(p, per, t))) begin
                    errors++;
                    $display("FAIL rand_irq p=%0d mode=%0d im=%b t=%0d got=%b exp=%b", p, mode, im, t, bus.irq, im & exp_flag(p, per, t));
                end
                step();
            end
            if (!per) begin
                bus_read(CTRL_OFS, v);
                checks++;
                if (v !== {28'h0, im, mode, 1'b0}) begin
                    errors++;
                    $display("FAIL rand_ctrl got=%h exp=%h", v, {28'h0, im, mode, 1'b0});
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.addr  = BASE;
        bus.wdata = '0;
        bus.we    = 1'b0;
        step();
        test_reset();
        test_regs();
        test_oneshot();
        test_periodic();
        test_zero_preset();
        test_disable();
        test_masked();
        test_int_priority();
        test_reset_midcount();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
